ktop_nstream_vop: RTL

- Parametrised successor to the single-stream vector-add core.
- Joins C_NUM_INPUTS AXI4-Stream inputs beat-by-beat and applies a runtime-selected lane-wise operation plus a constant.
- Emits one AXI4-Stream output carrying a generated tlast, and signals completion after a programmed beat count.
- Sits between N read masters and one write master in the kernel datapath.

---
 rtl/ktop_nstream_vop_if.sv | 22 ++
 rtl/ktop_nstream_vop.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ktop_nstream_vop_if.sv
// ktop_nstream_vop_if: bundles the N AXI4-Stream inputs and the single AXI4-Stream output of ktop_nstream_vop.
interface ktop_nstream_vop_if #(
    parameter int N = 4,
    parameter int W = 512
);
    logic [N-1:0]   s_axis_tvalid;
    logic [N-1:0]   s_axis_tready;
    logic [N*W-1:0] s_axis_tdata;
    logic [N-1:0]   s_axis_tlast;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic [W-1:0]   m_axis_tdata;
    logic           m_axis_tlast;
    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );
    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );
endinterface

// File: rtl/ktop_nstream_vop.sv
// ktop_nstream_vop: joins N AXI4-Stream inputs beat-by-beat, applies a lane-wise sum/max/min/xor plus constant.
// Define KTOP_NSTREAM_VOP_SATURATE_EN to saturate modes 0-2 instead of wrapping.
module ktop_nstream_vop #(
    parameter int C_NUM_INPUTS       = 4,
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_LANE_WIDTH       = 32,
    parameter int C_FIFO_DEPTH       = 4,
    parameter int C_COUNT_WIDTH      = 32
)(
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     ctrl_start,
    input  logic [1:0]               ctrl_mode,
    input  logic [C_LANE_WIDTH-1:0]  ctrl_constant,
    input  logic [C_COUNT_WIDTH-1:0] ctrl_beats,
    output logic                     ctrl_done,
    output logic                     err_tlast,
    ktop_nstream_vop_if.slave        axis
);
    localparam int N  = C_NUM_INPUTS;
    localparam int W  = C_AXIS_TDATA_WIDTH;
    localparam int LW = C_LANE_WIDTH;
    localparam int D  = C_FIFO_DEPTH;
    localparam int CW = C_COUNT_WIDTH;
    localparam int L  = W / LW;
    localparam int AW = $clog2(D);
    localparam int PW = AW + 1;
`ifdef KTOP_NSTREAM_VOP_SATURATE_EN
    localparam int SW = LW + 4;
    localparam int XW = LW + 1;
`else
    localparam int SW = LW;
    localparam int XW = LW;
`endif
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;

    logic [1:0]    state_q, state_d, mode_q, mode_d;
    logic [LW-1:0] cst_q, cst_d;
    logic [CW-1:0] beats_q, beats_d, joined_q, joined_d;
    logic [CW-1:0] acc_q [N];
    logic [CW-1:0] acc_d [N];
    logic [PW-1:0] wptr_q [N];
    logic [PW-1:0] wptr_d [N];
    logic [PW-1:0] rptr_q [N];
    logic [PW-1:0] rptr_d [N];
    logic [W:0]    fifo_mem [N][D];
    logic [W:0]    head [N];
    logic [N-1:0]  full, empty, push, heads_last, s_ready;
    logic          pop, last_beat, err_q, err_d;
    logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [W-1:0]  out_data_q, out_data_d, res;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            head[i]       = fifo_mem[i][rptr_q[i][AW-1:0]];
            heads_last[i] = head[i][W];
            empty[i]      = wptr_q[i] == rptr_q[i];
            full[i]       = (wptr_q[i] - rptr_q[i]) == PW'(D);
        end
        pop       = state_q == RUN && ~|empty && (!out_valid_q || axis.m_axis_tready);
        last_beat = (joined_q + CW'(1)) == beats_q;
        // A full FIFO may still accept when the same cycle pops it.
        for (int i = 0; i < N; i++)
            s_ready[i] = state_q == RUN && acc_q[i] < beats_q && (!full[i] || pop);
        push = axis.s_axis_tvalid & s_ready;
    end

    always_comb begin : lane_calc
        logic [SW-1:0] sum;
        logic [LW-1:0] v, mx, mn, xr, s0, s1, s2;
        logic [XW-1:0] mxc, mnc;
        res = '0;
        for (int l = 0; l < L; l++) begin
            sum = SW'(cst_q);
            mx  = '0;
            mn  = '1;
            xr  = cst_q;
            for (int i = 0; i < N; i++) begin
                v   = head[i][l*LW +: LW];
                sum = sum + SW'(v);
                mx  = v > mx ? v : mx;
                mn  = v < mn ? v : mn;
                xr  = xr ^ v;
            end
            mxc = XW'(mx) + XW'(cst_q);
            mnc = XW'(mn) + XW'(cst_q);
`ifdef KTOP_NSTREAM_VOP_SATURATE_EN
            s0 = |sum[SW-1:LW] ? '1 : sum[LW-1:0];
            s1 = mxc[LW] ? '1 : mxc[LW-1:0];
            s2 = mnc[LW] ? '1 : mnc[LW-1:0];
`else
            s0 = sum;
            s1 = mxc;
            s2 = mnc;
`endif
            res[l*LW +: LW] = mode_q == 2'd0 ? s0 : mode_q == 2'd1 ? s1 : mode_q == 2'd2 ? s2 : xr;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cst_d       = cst_q;
        beats_d     = beats_q;
        joined_d    = joined_q + CW'(pop);
        err_d       = err_q | (pop && heads_last != {N{last_beat}});
        out_valid_d = pop | (out_valid_q & ~axis.m_axis_tready);
        out_data_d  = pop ? res : out_data_q;
        out_last_d  = pop ? last_beat : out_last_q;
        for (int i = 0; i < N; i++) begin
            acc_d[i]  = acc_q[i] + CW'(push[i]);
            wptr_d[i] = wptr_q[i] + PW'(push[i]);
            rptr_d[i] = rptr_q[i] + PW'(pop);
        end
        if (state_q == IDLE && ctrl_start) begin
            mode_d   = ctrl_mode;
            cst_d    = ctrl_constant;
            beats_d  = ctrl_beats;
            joined_d = '0;
            err_d    = 1'b0;
            for (int i = 0; i < N; i++) acc_d[i] = '0;
            state_d  = ctrl_beats == '0 ? DONE : RUN;
        end
        if (state_q == RUN && pop && last_beat) state_d = DRAIN;
        if (state_q == DRAIN && out_valid_q && axis.m_axis_tready && out_last_q) state_d = DONE;
        if (state_q == DONE) state_d = IDLE;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            cst_q       <= '0;
            beats_q     <= '0;
            joined_q    <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                acc_q[i]  <= '0;
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cst_q       <= cst_d;
            beats_q     <= beats_d;
            joined_q    <= joined_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            for (int i = 0; i < N; i++) begin
                acc_q[i]  <= acc_d[i];
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
            end
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers alone.
    always_ff @(posedge aclk) begin
        for (int i = 0; i < N; i++)
            if (push[i]) fifo_mem[i][wptr_q[i][AW-1:0]] <= {axis.s_axis_tlast[i], axis.s_axis_tdata[i*W +: W]};
    end

    assign axis.s_axis_tready = s_ready;
    assign axis.m_axis_tvalid = out_valid_q;
    assign axis.m_axis_tdata  = out_data_q;
    assign axis.m_axis_tlast  = out_last_q;
    assign ctrl_done          = state_q == DONE;
    assign err_tlast          = err_q;
endmodule
